// File: rtl/reg_dump.sv
// Purpose : streams a window of the register file (FIRST_REG..LAST_REG) out as a valid/ready word stream with a running checksum, freezing the CPU meanwhile.
// Latency : one READ cycle then one SEND cycle per word; first out_valid one edge after start is taken, full 32-register dump completes in 64 edges.
// Backpr. : out_ready low holds SEND with out_data/out_index/out_last frozen; no word is dropped or repeated; abort cancels at any point.

module reg_dump #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic        hold_cpu,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_index,
   output logic        out_last,
   output logic        done,
   output logic [31:0] checksum
);

   // Register window bounds narrowed to the address width; callers keep
   // FIRST_REG <= LAST_REG <= 31.
   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state;
   logic [4:0] index;

   // The read address is always the current index; it parks on FIRST_REG
   // while idle so the first read of a new dump needs no extra setup.
   assign rf_addr = index;

   // Dump sequencer: all outputs are registered and move together with the
   // state, so out_valid/hold_cpu/done never glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         index     <= FIRST_IDX;
         hold_cpu  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_index <= 5'd0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         checksum  <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // abort outranks a simultaneous start
               if (start && !abort) begin
                  state    <= READ;
                  index    <= FIRST_IDX;
                  checksum <= 32'd0;
                  hold_cpu <= 1'b1;
               end
            end

            READ: begin
               if (abort) begin
                  state     <= IDLE;
                  index     <= FIRST_IDX;
                  hold_cpu  <= 1'b0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else begin
                  // capture the word; the register file is frozen, so the
                  // holding register can present it for as long as needed
                  out_data  <= rf_data;
                  out_index <= index;
                  out_last  <= (index == LAST_IDX);
                  out_valid <= 1'b1;
                  state     <= SEND;
               end
            end

            SEND: begin
               if (abort) begin
                  // a handshake in the same cycle is discarded with the dump
                  state     <= IDLE;
                  index     <= FIRST_IDX;
                  hold_cpu  <= 1'b0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else if (out_ready) begin
                  checksum  <= checksum + out_data;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (index == LAST_IDX) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     index <= index + 5'd1;
                     state <= READ;
                  end
               end
            end

            DONE: begin
               // single-cycle completion; checksum is left for the reader
               state    <= IDLE;
               index    <= FIRST_IDX;
               hold_cpu <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               index     <= FIRST_IDX;
               hold_cpu  <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

   // A stalled word must stay exactly as presented until it is taken.
   a_stall_stable : assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid && !out_ready && !abort) |=>
         (out_valid && $stable(out_data) && $stable(out_index) && $stable(out_last)));

   // The CPU is frozen whenever a word is on offer.
   a_valid_holds_cpu : assert property (@(posedge clk) disable iff (!reset_n)
      out_valid |-> hold_cpu);

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

   logic        clk;
   logic        reset_n;

   // default instance: full 0..31 window
   logic        start, abort, out_ready;
   logic [4:0]  rf_addr, out_index;
   logic [31:0] rf_data, out_data, checksum;
   logic        hold_cpu, out_valid, out_last, done;

   // second instance: 8..12 window
   logic        start_b, abort_b, out_ready_b;
   logic [4:0]  rf_addr_b, out_index_b;
   logic [31:0] rf_data_b, out_data_b, checksum_b;
   logic        hold_cpu_b, out_valid_b, out_last_b, done_b;

   logic [31:0] rf [32];

   assign rf_data   = rf[rf_addr];
   assign rf_data_b = rf[rf_addr_b];

   reg_dump dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .rf_addr(rf_addr), .rf_data(rf_data), .hold_cpu(hold_cpu),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .done(done), .checksum(checksum)
   );

   reg_dump #(.FIRST_REG(8), .LAST_REG(12)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
      .rf_addr(rf_addr_b), .rf_data(rf_data_b), .hold_cpu(hold_cpu_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_index(out_index_b), .out_last(out_last_b), .done(done_b), .checksum(checksum_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // words accepted during the latest run_dump
   logic [31:0] wd [64];
   logic [4:0]  wi [64];
   logic        wl [64];
   int          n_words, first_vld, done_cyc, done_cnt;

   // Start a dump on the default instance and watch it to completion.
   // cyc counts edges after the start edge; samples are taken 1 time unit
   // after each rising edge. stall_word/stall_len hold out_ready low on that
   // word; start_at re-asserts start mid-dump (must be ignored).
   task automatic run_dump(input int stall_word, input int stall_len, input int start_at);
      int          cyc;
      int          stall_cnt;
      logic [31:0] hd;
      logic [4:0]  hi;
      logic        hl;
      logic        timed_out;
      n_words = 0; first_vld = -1; done_cyc = -1; done_cnt = 0;
      stall_cnt = 0; timed_out = 1'b1; hd = '0; hi = '0; hl = 1'b0;
      start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      check("read_vld", 32'(out_valid), 32'd0);
      check("read_hold", 32'(hold_cpu), 32'd1);
      while (cyc < 300) begin
         if (out_valid && first_vld < 0) first_vld = cyc;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end else if (done_cnt > 0) begin
            timed_out = 1'b0;
            break;
         end
         start = (cyc == start_at);
         out_ready = 1'b1;
         if (stall_cnt > 0 && stall_cnt <= stall_len) begin
            check("stall_vld", 32'(out_valid), 32'd1);
            check("stall_dat", out_data, hd);
            check("stall_idx", 32'(out_index), 32'(hi));
            check("stall_last", 32'(out_last), 32'(hl));
         end
         if (stall_cnt < stall_len && (stall_cnt > 0 || (out_valid && n_words == stall_word))) begin
            out_ready = 1'b0;
            if (stall_cnt == 0) begin
               hd = out_data; hi = out_index; hl = out_last;
            end
            stall_cnt++;
         end else if (stall_len > 0 && stall_cnt == stall_len) begin
            stall_cnt++;
         end
         if (out_valid && out_ready && n_words < 64) begin
            wd[n_words] = out_data;
            wi[n_words] = out_index;
            wl[n_words] = out_last;
            n_words++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      check("dump_timeout", 32'(timed_out), 32'd0);
   endtask

   // check a full 0..31 dump against the register model
   task automatic check_full(input string tag, input int exp_done_cyc);
      logic [31:0] sum;
      sum = 32'd0;
      check({tag, "_nwords"}, 32'(n_words), 32'd32);
      check({tag, "_first_vld"}, 32'(first_vld), 32'd1);
      check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
      check({tag, "_done_width"}, 32'(done_cnt), 32'd1);
      for (int i = 0; i < 32; i++) begin
         sum = sum + rf[i];
         if (i < n_words) begin
            check({tag, "_idx"}, 32'(wi[i]), 32'(i));
            check({tag, "_dat"}, wd[i], rf[i]);
            check({tag, "_last"}, 32'(wl[i]), (i == 31) ? 32'd1 : 32'd0);
         end
      end
      check({tag, "_csum"}, checksum, sum);
      check({tag, "_idle_hold"}, 32'(hold_cpu), 32'd0);
      check({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_idle_addr"}, 32'(rf_addr), 32'd0);
   endtask

   initial begin
      logic [31:0] part;
      logic        found;
      int          nb;
      int          bdone;

      reset_n = 1'b1;
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;

      // ---- asynchronous reset values (no clock edge between) ----
      #2 reset_n = 1'b0;
      #2;
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_hold", 32'(hold_cpu), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_dat", out_data, 32'd0);
      check("rst_idx", 32'(out_index), 32'd0);
      check("rst_csum", checksum, 32'd0);
      check("rst_addr", 32'(rf_addr), 32'd0);
      check("rst_addr_b", 32'(rf_addr_b), 32'd8);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // ---- full dump: reg16=F0, reg17=0F, rest 0 ----
      rf[16] = 32'h0000_00F0;
      rf[17] = 32'h0000_000F;
      run_dump(-1, 0, -1);
      check_full("full", 64);
      check("full_csum_ff", checksum, 32'h0000_00FF);

      // ---- backpressure on word 8 plus a mid-dump start that is ignored;
      //      reg0 non-zero to show index 0 is an ordinary word ----
      for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * (i + 1) + 32'hF000_0000;
      run_dump(8, 5, 20);
      check_full("bp", 69);

      // ---- checksum holds in idle ----
      part = checksum;
      repeat (3) @(posedge clk);
      #1 check("idle_csum_hold", checksum, part);

      // ---- abort while word 5 is on offer, with out_ready high ----
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid && out_index == 5'd5) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("abort_found", 32'(found), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      part = rf[0] + rf[1] + rf[2] + rf[3] + rf[4];
      check("abort_vld", 32'(out_valid), 32'd0);
      check("abort_hold", 32'(hold_cpu), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_csum", checksum, part);
      check("abort_addr", 32'(rf_addr), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("abort_nodone", 32'(done), 32'd0);
      end
      run_dump(-1, 0, -1);
      check_full("after_abort", 64);

      // ---- start and abort together in idle: stays idle ----
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("sa_hold", 32'(hold_cpu), 32'd0);
      @(posedge clk); #1;
      check("sa_vld", 32'(out_valid), 32'd0);
      check("sa_hold2", 32'(hold_cpu), 32'd0);

      // ---- reset pulsed mid-SEND, between clock edges ----
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid && out_index == 5'd3) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("rst2_found", 32'(found), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst2_vld", 32'(out_valid), 32'd0);
      check("rst2_hold", 32'(hold_cpu), 32'd0);
      check("rst2_dat", out_data, 32'd0);
      check("rst2_idx", 32'(out_index), 32'd0);
      check("rst2_csum", checksum, 32'd0);
      check("rst2_addr", 32'(rf_addr), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst2_idle_vld", 32'(out_valid), 32'd0);
      run_dump(-1, 0, -1);
      check_full("after_rst", 64);

      // ---- window 8..12 on the second instance, wrapping checksum ----
      rf[8]  = 32'h0000_00FF;
      rf[9]  = 32'h0000_00F0;
      rf[10] = 32'h0000_00CF;
      rf[11] = 32'h0000_00FC;
      rf[12] = 32'hFFFF_FFFF;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      check("win_read_addr", 32'(rf_addr_b), 32'd8);
      nb = 0; bdone = -1;
      for (int k = 1; k < 100; k++) begin
         @(posedge clk); #1;
         if (out_valid_b && out_ready_b) begin
            check("win_idx", 32'(out_index_b), 32'(8 + nb));
            check("win_dat", out_data_b, rf[8 + nb]);
            check("win_last", 32'(out_last_b), (nb == 4) ? 32'd1 : 32'd0);
            nb++;
         end
         if (done_b) begin
            bdone = k;
            break;
         end
      end
      check("win_nwords", 32'(nb), 32'd5);
      check("win_done_cyc", 32'(bdone), 32'd10);
      check("win_csum", checksum_b, 32'h0000_03B9);
      @(posedge clk); #1;
      check("win_done_width", 32'(done_b), 32'd0);
      check("win_idle_hold", 32'(hold_cpu_b), 32'd0);
      check("win_idle_addr", 32'(rf_addr_b), 32'd8);
      check("win_csum_hold", checksum_b, 32'h0000_03B9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
